// File: rtl/jt08_adpcmb_memwr.sv
// CPU-to-sample-RAM writer for the ADPCM-B channel.
// CPU bytes are written one at a time from astart up to aend inclusive.
// The address wraps to 0 after alimit. The writer also drives the
// BRDY/EOS/overrun status bits toward the register bank.
module jt08_adpcmb_memwr #(
   parameter int AW = 21,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          clr,
   input  logic [AW-1:0] astart,
   input  logic [AW-1:0] aend,
   input  logic [AW-1:0] alimit,
   input  logic [DW-1:0] din,
   input  logic          din_wr,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_dout,
   input  logic          mem_ack,
   output logic          busy,
   output logic          brdy,
   output logic          eos,
   input  logic          clr_flag,
   output logic          ovr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] ADDR_ZERO = '0;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_dout_q, mem_dout_d;
   logic          mem_we_q, mem_we_d;
   logic          brdy_q, brdy_d;
   logic          busy_q, busy_d;
   logic          eos_q, eos_d;
   logic          ovr_q, ovr_d;
   logic          byte_ok;

   // Next-state logic. clr beats start, and start beats everything else.
   // Flag clears are applied first, so any set in the same cycle overrides them.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      mem_addr_d = mem_addr_q;
      mem_dout_d = mem_dout_q;
      mem_we_d   = mem_we_q;
      brdy_d     = brdy_q;
      eos_d      = eos_q;
      ovr_d      = ovr_q;
      byte_ok    = (state_q == ARMED) && !clr && !start;

      if (clr_flag) begin
         eos_d = 1'b0;
         ovr_d = 1'b0;
      end
      if (din_wr && !byte_ok) begin
         ovr_d = 1'b1;
      end

      if (clr) begin
         state_d  = IDLE;
         mem_we_d = 1'b0;
         brdy_d   = 1'b0;
      end else if (start) begin
         state_d  = ARMED;
         addr_d   = astart;
         mem_we_d = 1'b0;
         brdy_d   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               brdy_d   = 1'b0;
               mem_we_d = 1'b0;
            end
            ARMED: begin
               if (din_wr) begin
                  state_d    = WRITE;
                  mem_dout_d = din;
                  mem_addr_d = addr_q;
                  mem_we_d   = 1'b1;
                  brdy_d     = 1'b0;
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  mem_we_d = 1'b0;
                  if (addr_q == aend) begin
                     eos_d   = 1'b1;
                     state_d = IDLE;
                     brdy_d  = 1'b0;
                  end else begin
                     addr_d  = (addr_q == alimit) ? ADDR_ZERO : addr_q + ADDR_ONE;
                     state_d = ARMED;
                     brdy_d  = 1'b1;
                  end
               end
            end
            default: begin
               state_d  = IDLE;
               mem_we_d = 1'b0;
               brdy_d   = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         mem_addr_q <= '0;
         mem_dout_q <= '0;
         mem_we_q   <= 1'b0;
         brdy_q     <= 1'b0;
         busy_q     <= 1'b0;
         eos_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         mem_addr_q <= mem_addr_d;
         mem_dout_q <= mem_dout_d;
         mem_we_q   <= mem_we_d;
         brdy_q     <= brdy_d;
         busy_q     <= busy_d;
         eos_q      <= eos_d;
         ovr_q      <= ovr_d;
      end
   end

   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_dout = mem_dout_q;
   assign busy     = busy_q;
   assign brdy     = brdy_q;
   assign eos      = eos_q;
   assign ovr      = ovr_q;

endmodule

// File: tb/tb_jt08_adpcmb_memwr.sv
// Self-checking bench for jt08_adpcmb_memwr.
// A session model turns each start into the list of addresses the session
// must visit. Each byte the bench expects the DUT to accept is queued as an
// expected RAM write. The compare process pops that queue on every
// acknowledged write and checks that the RAM port holds steady while a
// request is pending.
module tb_jt08_adpcmb_memwr;

   localparam int AW = 21;
   localparam int DW = 8;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, clr, din_wr, mem_ack, clr_flag;
   logic [AW-1:0] astart, aend, alimit;
   logic [DW-1:0] din;
   logic          mem_we, busy, brdy, eos, ovr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout;

   int            tests_run = 0;
   int            tests_failed = 0;

   logic [AW-1:0] sess_q[$];
   wr_t           exp_q[$];
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_data;
   logic          prev_we;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_dout;

   jt08_adpcmb_memwr #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .clr(clr),
      .astart(astart), .aend(aend), .alimit(alimit),
      .din(din), .din_wr(din_wr),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_ack(mem_ack),
      .busy(busy), .brdy(brdy), .eos(eos), .clr_flag(clr_flag), .ovr(ovr)
   );

   // Free-running clock with rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Session model: the address sequence that a session must walk.
   task automatic start_session(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [AW-1:0] l);
      logic [AW-1:0] a;
      sess_q.delete();
      a = s;
      for (int n = 0; n < 64; n++) begin
         sess_q.push_back(a);
         if (a == e) break;
         if (a == l) a = '0;
         else a = a + 21'd1;
      end
      astart = s; aend = e; alimit = l;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic expect_byte(input logic [DW-1:0] d);
      wr_t w;
      if (sess_q.size() == 0) begin
         tests_run++; tests_failed++;
         $display("[TB] FAIL session_overflow: got 1 expected 0");
      end else begin
         w.a = sess_q.pop_front();
         w.d = d;
         exp_q.push_back(w);
      end
   endtask

   // Send one byte and acknowledge it after 'delay' cycles of mem_we.
   task automatic applyStimulus(input logic [DW-1:0] d, input int delay);
      din = d; din_wr = 1'b1;
      @(posedge clk); #1;
      din_wr = 1'b0;
      check("mem_we_latency", 32'(mem_we), 32'd1);
      expect_byte(d);
      repeat (delay) begin
         @(posedge clk); #1;
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
      check({name, "_addr"}, 32'(last_addr), 32'(a));
      check({name, "_data"}, 32'(last_data), 32'(d));
   endtask

   // Scoreboard: on every cycle, pop an expected write when one is
   // accepted, and require a stable RAM port while a request is pending.
   always @(negedge clk) begin
      if (rst) begin
         prev_we = 1'b0;
      end else begin
         if (mem_we && prev_we) begin
            check("addr_stable", 32'(mem_addr), 32'(prev_addr));
            check("dout_stable", 32'(mem_dout), 32'(prev_dout));
         end
         if (brdy && mem_we) check("brdy_vs_we", 32'd1, 32'd0);
         if (mem_we && mem_ack) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'(mem_addr), 32'h0FFFFFFF);
            end else begin
               wr_t w;
               w = exp_q.pop_front();
               check("sb_addr", 32'(mem_addr), 32'(w.a));
               check("sb_data", 32'(mem_dout), 32'(w.d));
               last_addr = mem_addr;
               last_data = mem_dout;
            end
         end
         prev_we   = mem_we;
         prev_addr = mem_addr;
         prev_dout = mem_dout;
      end
   end

   initial begin
      rst = 1'b1; start = 0; clr = 0; din_wr = 0; mem_ack = 0; clr_flag = 0;
      astart = '0; aend = '0; alimit = '0; din = '0;
      last_addr = '0; last_data = '0; prev_we = 0; prev_addr = '0; prev_dout = '0;
      #1;
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_dout", 32'(mem_dout), 32'd0);
      check("rst_flags", {28'd0, busy, brdy, eos, ovr}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic session of three bytes, each acked one cycle after mem_we.
      start_session(21'h10, 21'h12, 21'h1FFFFF);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_brdy", 32'(brdy), 32'd1);
      applyStimulus(8'hA1, 1); checkOutput("t1_b0", 21'h10, 8'hA1);
      check("t1_brdy_mid", 32'(brdy), 32'd1);
      applyStimulus(8'hA2, 1); checkOutput("t1_b1", 21'h11, 8'hA2);
      check("t1_eos_mid", 32'(eos), 32'd0);
      applyStimulus(8'hA3, 1); checkOutput("t1_b2", 21'h12, 8'hA3);
      check("t1_eos", 32'(eos), 32'd1);
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_brdy_end", 32'(brdy), 32'd0);

      // clr_flag clears eos.
      clr_flag = 1'b1; @(posedge clk); #1 clr_flag = 1'b0;
      check("t5_eos_clr", 32'(eos), 32'd0);

      // Wrap at alimit, with immediate acks.
      start_session(21'h1FFFFE, 21'h000001, 21'h1FFFFF);
      applyStimulus(8'h01, 0); checkOutput("t2_b0", 21'h1FFFFE, 8'h01);
      applyStimulus(8'h02, 0); checkOutput("t2_b1", 21'h1FFFFF, 8'h02);
      applyStimulus(8'h03, 0); checkOutput("t2_b2", 21'h000000, 8'h03);
      check("t2_eos_mid", 32'(eos), 32'd0);
      applyStimulus(8'h04, 0); checkOutput("t2_b3", 21'h000001, 8'h04);
      check("t2_eos", 32'(eos), 32'd1);
      check("t2_busy", 32'(busy), 32'd0);

      // clr while a write is pending. start leaves eos alone, and so does clr.
      start_session(21'h80, 21'h85, 21'h1FFFFF);
      check("t4_eos_kept_by_start", 32'(eos), 32'd1);
      din = 8'h77; din_wr = 1'b1; @(posedge clk); #1 din_wr = 1'b0;
      check("t4_we", 32'(mem_we), 32'd1);
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      check("t4_we_off", 32'(mem_we), 32'd0);
      check("t4_brdy", 32'(brdy), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_eos", 32'(eos), 32'd1);

      // Single-byte session. clr_flag on the final ack loses to the set.
      clr_flag = 1'b1; @(posedge clk); #1 clr_flag = 1'b0;
      check("t5_eos_clr2", 32'(eos), 32'd0);
      start_session(21'h20, 21'h20, 21'h1FFFFF);
      din = 8'h5A; din_wr = 1'b1; @(posedge clk); #1 din_wr = 1'b0;
      expect_byte(8'h5A);
      mem_ack = 1'b1; clr_flag = 1'b1;
      @(posedge clk); #1 mem_ack = 1'b0; clr_flag = 1'b0;
      checkOutput("t5_one", 21'h20, 8'h5A);
      check("t5_eos_set_wins", 32'(eos), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);

      // Ack delayed five cycles, with a second byte arriving during WRITE.
      start_session(21'h40, 21'h45, 21'h1FFFFF);
      din = 8'h55; din_wr = 1'b1; @(posedge clk); #1 din_wr = 1'b0;
      expect_byte(8'h55);
      @(posedge clk); #1;
      din = 8'h66; din_wr = 1'b1; @(posedge clk); #1 din_wr = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("t3_addr_held", 32'(mem_addr), 32'h40);
      check("t3_dout_held", 32'(mem_dout), 32'h55);
      check("t3_ovr", 32'(ovr), 32'd1);
      mem_ack = 1'b1; @(posedge clk); #1 mem_ack = 1'b0;
      checkOutput("t3_b0", 21'h40, 8'h55);
      check("t3_brdy", 32'(brdy), 32'd1);
      check("t3_we_off", 32'(mem_we), 32'd0);
      clr_flag = 1'b1; @(posedge clk); #1 clr_flag = 1'b0;
      check("t3_ovr_clr", 32'(ovr), 32'd0);
      check("t3_eos_clr", 32'(eos), 32'd0);

      // start and din_wr together: start wins and the byte is an overrun.
      astart = 21'h60; aend = 21'h61;
      din = 8'h99; din_wr = 1'b1; start = 1'b1;
      @(posedge clk); #1 din_wr = 1'b0; start = 1'b0;
      check("sd_ovr", 32'(ovr), 32'd1);
      check("sd_we", 32'(mem_we), 32'd0);
      check("sd_brdy", 32'(brdy), 32'd1);
      clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
      check("sd_ovr_kept_by_clr", 32'(ovr), 32'd1);

      // Asynchronous reset in the middle of a pending write.
      start_session(21'h100, 21'h102, 21'h1FFFFF);
      din = 8'hC0; din_wr = 1'b1; @(posedge clk); #1 din_wr = 1'b0;
      check("t6_we", 32'(mem_we), 32'd1);
      #3 rst = 1'b1;
      #1;
      check("t6_rst_we", 32'(mem_we), 32'd0);
      check("t6_rst_addr", 32'(mem_addr), 32'd0);
      check("t6_rst_dout", 32'(mem_dout), 32'd0);
      check("t6_rst_flags", {28'd0, busy, brdy, eos, ovr}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      start_session(21'h100, 21'h102, 21'h1FFFFF);
      applyStimulus(8'hB1, 0); checkOutput("t6_b0", 21'h100, 8'hB1);
      // A start while busy restarts at astart.
      start_session(21'h100, 21'h102, 21'h1FFFFF);
      applyStimulus(8'hB2, 2); checkOutput("t6_restart", 21'h100, 8'hB2);
      check("t6_busy", 32'(busy), 32'd1);

      repeat (2) @(posedge clk);
      #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
